csr_trap_unit: RTL and testbench

Machine-mode CSR file and trap sequencer sitting directly downstream of the exception decoder in the execute stage. Consumes the decoder's ecall/mret/csrWrite/csrSrc/csrLUCtrl strobes, performs CSR read-modify-write, and sequences trap entry and return. Holds mstatus/mtvec/mscratch/mepc/mcause and, optionally, mcycle. Drives a one-cycle PC redirect to fetch.

---
 rtl/csr_pkg.sv | 33 +++
 rtl/csr_alu.sv | 21 ++
 rtl/csr_trap_unit.sv | 165 ++++++++++++++++
 tb/tb_csr_trap_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR file and trap sequencer.
package csr_pkg;

  localparam int XLEN = 32;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  localparam logic [XLEN-1:0] MCAUSE_ECALL_M = 32'd11;

  typedef enum logic [1:0] {
    LU_NOP   = 2'b00,
    LU_WRITE = 2'b01,
    LU_SET   = 2'b10,
    LU_CLEAR = 2'b11
  } csr_lu_e;

  typedef enum logic {
    S_IDLE,
    S_REDIRECT
  } state_e;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/csr_alu.sv
// CSR read-modify-write combiner: write, set or clear the old value.
module csr_alu
  import csr_pkg::*;
(
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_op,
  input  logic [1:0]      i_ctrl,
  output logic [XLEN-1:0] o_new
);

  always_comb begin
    o_new = i_old;
    case (i_ctrl)
      LU_WRITE: o_new = i_op;
      LU_SET:   o_new = i_old | i_op;
      LU_CLEAR: o_new = i_old & ~i_op;
      default:  o_new = i_old;
    endcase
  end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and ecall/mret trap sequencer with a one-cycle redirect.
// Optional 64-bit mcycle counter is built when CSR_MCYCLE_EN is defined.
module csr_trap_unit
  import csr_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic            i_ecall,
  input  logic            i_mret,
  input  logic            i_csrWrite,
  input  logic            i_csrSrc,
  input  logic [1:0]      i_csrLUCtrl,
  input  logic [11:0]     i_csrAddr,
  input  logic [XLEN-1:0] i_rs1Data,
  input  logic [4:0]      i_zimm,
  input  logic [XLEN-1:0] i_pc,
  output logic [XLEN-1:0] o_csrRdata,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirectPc,
  output logic            o_busy
);

  state_e          state_q, state_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
`ifdef CSR_MCYCLE_EN
  logic [63:0]     mcycle_q, mcycle_d;
`endif

  logic [XLEN-1:0] csr_rdata;
  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] wdata;
  logic            idle;
  logic            take_ecall;
  logic            take_mret;
  logic            do_write;

  always_comb begin
    csr_rdata = '0;
    case (i_csrAddr)
      CSR_MSTATUS: begin
        csr_rdata[MSTATUS_MIE]  = mie_q;
        csr_rdata[MSTATUS_MPIE] = mpie_q;
        csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MTVEC:    csr_rdata = mtvec_q;
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = mepc_q;
      CSR_MCAUSE:   csr_rdata = mcause_q;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE:   csr_rdata = mcycle_q[31:0];
      CSR_MCYCLEH:  csr_rdata = mcycle_q[63:32];
`endif
      default:      csr_rdata = '0;
    endcase
  end

  assign o_csrRdata = i_csrWrite ? csr_rdata : '0;
  assign operand    = i_csrSrc ? {27'd0, i_zimm} : i_rs1Data;

  csr_alu u_alu (
    .i_old  (csr_rdata),
    .i_op   (operand),
    .i_ctrl (i_csrLUCtrl),
    .o_new  (wdata)
  );

  // Priority ecall > mret > CSR write; REDIRECT swallows everything.
  assign idle       = (state_q == S_IDLE);
  assign take_ecall = i_valid & idle & i_ecall;
  assign take_mret  = i_valid & idle & i_mret & ~i_ecall;
  assign do_write   = i_valid & idle & i_csrWrite & ~i_ecall & ~i_mret
                    & (i_csrLUCtrl != LU_NOP);

  always_comb begin
    state_d       = S_IDLE;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (take_ecall) begin
      mepc_d        = {i_pc[31:2], 2'b00};
      mcause_d      = MCAUSE_ECALL_M;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      redirect_pc_d = {mtvec_q[31:2], 2'b00};
      redirect_d    = 1'b1;
      state_d       = S_REDIRECT;
    end else if (take_mret) begin
      mie_d         = mpie_q;
      mpie_d        = 1'b1;
      redirect_pc_d = mepc_q;
      redirect_d    = 1'b1;
      state_d       = S_REDIRECT;
    end else if (do_write) begin
      case (i_csrAddr)
        CSR_MSTATUS: begin
          mie_d  = wdata[MSTATUS_MIE];
          mpie_d = wdata[MSTATUS_MPIE];
        end
        CSR_MTVEC:    mtvec_d    = {wdata[31:2], 2'b00};
        CSR_MSCRATCH: mscratch_d = wdata;
        CSR_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
        CSR_MCAUSE:   mcause_d   = wdata;
        default:      ;
      endcase
    end
  end

`ifdef CSR_MCYCLE_EN
  // A written half takes the value as-is; the other half keeps counting.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (do_write && i_csrAddr == CSR_MCYCLE)
      mcycle_d[31:0] = wdata;
    if (do_write && i_csrAddr == CSR_MCYCLEH)
      mcycle_d[63:32] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mcycle_q <= '0;
    else     mcycle_q <= mcycle_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= '0;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign o_redirect   = redirect_q;
  assign o_redirectPc = redirect_pc_q;
  assign o_busy       = (state_q == S_REDIRECT);

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: behavioural CSR model plus literal checks.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ecall, i_mret, i_csrWrite, i_csrSrc;
  logic [1:0]  i_csrLUCtrl;
  logic [11:0] i_csrAddr;
  logic [31:0] i_rs1Data;
  logic [4:0]  i_zimm;
  logic [31:0] i_pc;
  logic [31:0] o_csrRdata;
  logic        o_redirect;
  logic [31:0] o_redirectPc;
  logic        o_busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_trap_unit dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_ecall      (i_ecall),
    .i_mret       (i_mret),
    .i_csrWrite   (i_csrWrite),
    .i_csrSrc     (i_csrSrc),
    .i_csrLUCtrl  (i_csrLUCtrl),
    .i_csrAddr    (i_csrAddr),
    .i_rs1Data    (i_rs1Data),
    .i_zimm       (i_zimm),
    .i_pc         (i_pc),
    .o_csrRdata   (o_csrRdata),
    .o_redirect   (o_redirect),
    .o_redirectPc (o_redirectPc),
    .o_busy       (o_busy)
  );

  // Architectural model: CSR values as named variables, trap state as a flag.
  logic        m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc;
  logic        m_redir;
  logic [31:0] m_rpc;

  function automatic logic [31:0] lu_apply(input logic [1:0] lu,
                                           input logic [31:0] old,
                                           input logic [31:0] op);
    if (lu == 2'b01) return op;
    if (lu == 2'b10) return old | op;
    if (lu == 2'b11) return old & ~op;
    return old;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h300)
      return 32'h0000_1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
    if (a == 12'h305) return m_mtvec;
    if (a == 12'h340) return m_mscratch;
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
`ifdef CSR_MCYCLE_EN
    if (a == 12'hB00) return m_cyc[31:0];
    if (a == 12'hB80) return m_cyc[63:32];
`endif
    return 32'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mie <= 1'b0; m_mpie <= 1'b0;
      m_mtvec <= 0; m_mscratch <= 0; m_mepc <= 0; m_mcause <= 0;
      m_cyc <= 0; m_redir <= 1'b0; m_rpc <= 0;
    end else begin
      logic [31:0] op, nv;
      op = i_csrSrc ? {27'd0, i_zimm} : i_rs1Data;
      nv = lu_apply(i_csrLUCtrl, m_read(i_csrAddr), op);
      m_redir <= 1'b0;
      m_cyc <= m_cyc + 64'd1;
      if (i_valid && !m_redir) begin
        if (i_ecall) begin
          m_mepc <= i_pc & ~32'd3;
          m_mcause <= 32'd11;
          m_mpie <= m_mie;
          m_mie <= 1'b0;
          m_rpc <= m_mtvec & ~32'd3;
          m_redir <= 1'b1;
        end else if (i_mret) begin
          m_mie <= m_mpie;
          m_mpie <= 1'b1;
          m_rpc <= m_mepc;
          m_redir <= 1'b1;
        end else if (i_csrWrite && i_csrLUCtrl != 2'b00) begin
          if (i_csrAddr == 12'h300) begin
            m_mie <= nv[3];
            m_mpie <= nv[7];
          end
          if (i_csrAddr == 12'h305) m_mtvec <= nv & ~32'd3;
          if (i_csrAddr == 12'h340) m_mscratch <= nv;
          if (i_csrAddr == 12'h341) m_mepc <= nv & ~32'd3;
          if (i_csrAddr == 12'h342) m_mcause <= nv;
`ifdef CSR_MCYCLE_EN
          if (i_csrAddr == 12'hB00)
            m_cyc <= ((m_cyc + 64'd1) & 64'hFFFF_FFFF_0000_0000) | {32'd0, nv};
          if (i_csrAddr == 12'hB80)
            m_cyc <= ((m_cyc + 64'd1) & 64'h0000_0000_FFFF_FFFF) | {nv, 32'd0};
`endif
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle outside reset, mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_redirect", 32'(o_redirect), 32'(m_redir));
      chk("model_busy", 32'(o_busy), 32'(m_redir));
      if (m_redir) chk("model_redirect_pc", o_redirectPc, m_rpc);
      if (i_csrWrite) chk("model_rdata", o_csrRdata, m_read(i_csrAddr));
    end
  end

  task automatic apply(input logic v, input logic e, input logic m,
                       input logic w, input logic s, input logic [1:0] lu,
                       input logic [11:0] a, input logic [31:0] rs1,
                       input logic [4:0] z, input logic [31:0] pc);
    i_valid = v; i_ecall = e; i_mret = m; i_csrWrite = w; i_csrSrc = s;
    i_csrLUCtrl = lu; i_csrAddr = a; i_rs1Data = rs1; i_zimm = z; i_pc = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    apply(0, 0, 0, 0, 0, 2'b00, 12'h000, 0, 0, 0);
  endtask

  task automatic rd(input string nm, input logic [11:0] a,
                    input logic [31:0] exp);
    apply(0, 0, 0, 1, 0, 2'b00, a, 32'hDEAD_BEEF, 0, 0);
    #2 chk(nm, o_csrRdata, exp);
    tick();
  endtask

  task automatic ecall_at(input logic [31:0] pc);
    apply(1, 1, 0, 0, 0, 2'b00, 12'h000, 0, 0, pc);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_redirect", 32'(o_redirect), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);
    chk("reset_redirect_pc", o_redirectPc, 32'd0);
    rst = 1'b0;
    tick();

    rd("reset_mstatus", 12'h300, 32'h0000_1800);
    rd("reset_mepc", 12'h341, 32'd0);
    rd("unmapped_read", 12'h7C0, 32'd0);

    // csrrw mtvec, then ecall
    apply(1, 0, 0, 1, 0, 2'b01, 12'h305, 32'h8000_0103, 0, 0);
    #2 chk("csrrw_mtvec_old", o_csrRdata, 32'd0);
    tick();
    ecall_at(32'h0000_0040);
    chk("ecall_redirect", 32'(o_redirect), 32'd1);
    chk("ecall_busy", 32'(o_busy), 32'd1);
    chk("ecall_target", o_redirectPc, 32'h8000_0100);
    // ecall during REDIRECT is ignored
    apply(1, 1, 0, 0, 0, 2'b00, 12'h000, 0, 0, 32'h0000_0999);
    tick();
    chk("redirect_one_cycle", 32'(o_redirect), 32'd0);
    chk("back_to_idle", 32'(o_busy), 32'd0);
    rd("ecall_mepc", 12'h341, 32'h0000_0040);
    rd("ecall_mcause", 12'h342, 32'd11);
    rd("mtvec_low_bits", 12'h305, 32'h8000_0100);

    // csrrsi mstatus MIE, ecall, mret
    apply(1, 0, 0, 1, 1, 2'b10, 12'h300, 0, 5'd8, 0);
    #2 chk("csrrsi_old", o_csrRdata, 32'h0000_1800);
    tick();
    rd("mie_set", 12'h300, 32'h0000_1808);
    ecall_at(32'h0000_0040);
    idle_in();
    tick();
    rd("mstatus_after_ecall", 12'h300, 32'h0000_1880);
    apply(1, 0, 1, 0, 0, 2'b00, 12'h000, 0, 0, 32'h0000_0200);
    tick();
    chk("mret_redirect", 32'(o_redirect), 32'd1);
    chk("mret_target", o_redirectPc, 32'h0000_0040);
    idle_in();
    tick();
    rd("mstatus_after_mret", 12'h300, 32'h0000_1888);

    // ecall beats csrWrite; mret with csrWrite drops the write
    apply(1, 0, 1, 1, 0, 2'b01, 12'h340, 32'h1234_5678, 0, 0);
    tick();
    idle_in();
    tick();
    rd("mret_drops_write", 12'h340, 32'd0);

    // csrrc on mscratch
    apply(1, 0, 0, 1, 0, 2'b01, 12'h340, 32'hFFFF_FFFF, 0, 0);
    tick();
    apply(1, 0, 0, 1, 0, 2'b11, 12'h340, 32'h0F0F_0F0F, 0, 0);
    #2 chk("csrrc_old", o_csrRdata, 32'hFFFF_FFFF);
    tick();
    rd("csrrc_new", 12'h340, 32'hF0F0_F0F0);

    // unqualified write does nothing; back-to-back writes to mcause
    apply(0, 0, 0, 1, 0, 2'b01, 12'h342, 32'h5555_5555, 0, 0);
    tick();
    apply(1, 0, 0, 1, 0, 2'b01, 12'h342, 32'hA5A5_0001, 0, 0);
    #2 chk("invalid_write_ignored", o_csrRdata, 32'd11);
    tick();
    apply(1, 0, 0, 1, 0, 2'b10, 12'h342, 32'h0000_0F00, 0, 0);
    #2 chk("b2b_write_visible", o_csrRdata, 32'hA5A5_0001);
    tick();
    rd("b2b_set", 12'h342, 32'hA5A5_0F01);

    // mepc written then used by mret next cycle
    apply(1, 0, 0, 1, 0, 2'b01, 12'h341, 32'h0000_1237, 0, 0);
    tick();
    apply(1, 0, 1, 0, 0, 2'b00, 12'h000, 0, 0, 0);
    tick();
    chk("mret_fresh_mepc", o_redirectPc, 32'h0000_1234);
    idle_in();
    tick();

    // reset during REDIRECT
    ecall_at(32'h0000_0080);
    chk("pre_reset_redirect", 32'(o_redirect), 32'd1);
    idle_in();
    rst = 1'b1;
    #1;
    chk("reset_aborts_redirect", 32'(o_redirect), 32'd0);
    chk("reset_aborts_busy", 32'(o_busy), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    rd("mstatus_after_reset", 12'h300, 32'h0000_1800);

`ifdef CSR_MCYCLE_EN
    apply(1, 0, 0, 1, 0, 2'b01, 12'hB80, 32'd0, 0, 0);
    tick();
    apply(1, 0, 0, 1, 0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0);
    tick();
    rd("mcycleh_before_wrap", 12'hB80, 32'd0);
    rd("mcycle_wrapped", 12'hB00, 32'd0);
    rd("mcycleh_after_wrap", 12'hB80, 32'd1);
    apply(1, 0, 0, 1, 0, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 0);
    tick();
    rd("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
`else
    apply(1, 0, 0, 1, 0, 2'b01, 12'hB00, 32'h1234_5678, 0, 0);
    tick();
    rd("mcycle_unmapped", 12'hB00, 32'd0);
    rd("mcycleh_unmapped", 12'hB80, 32'd0);
`endif

    idle_in();
    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
